// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port cache-to-memory arbiter: FSM encoding,
// port indices and default sizing.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam logic PORT_IC = 1'b0;
   localparam logic PORT_DC = 1'b1;

   localparam int DEF_BURST_LEN = 4;
   localparam int DEF_MAX_OUT   = 4;
   localparam int DEF_CNT_W     = 3;

endpackage

// File: rtl/mem_rsp_tracker.sv
// Outstanding-read counter for the arbiter. Responses that arrive with nothing
// outstanding are dropped, which also discards stale traffic after a reset.
module mem_rsp_tracker
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUT = DEF_MAX_OUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_inc,
   input  logic i_rsp,
   output logic o_rsp_ok,
   output logic o_full,
   output logic o_empty,
   output logic o_empty_next
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             inc_ok;

   assign o_empty  = (cnt_q == '0);
   assign o_rsp_ok = i_rsp && !o_empty;
   // A response landing this cycle frees a slot, so the requester may issue now.
   assign o_full   = (cnt_q >= MAX_CNT) && !o_rsp_ok;
   assign inc_ok   = i_inc && !o_full;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_ok && !o_rsp_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!inc_ok && o_rsp_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign o_empty_next = (cnt_d == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction- and data-cache word requests onto one memory port,
// granting one cache per burst and routing in-order read responses back.
//
// state | meaning
// IDLE  | no grant; pick next owner (round-robin on ties), all outputs 0
// GRANT | owner forwarded to memory, up to BURST_LEN beats
// DRAIN | burst full; wait for outstanding reads before re-arbitrating
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int MAX_OUT   = DEF_MAX_OUT,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_ic_ready,
   input  logic [31:0] i_ic_addr,
   input  logic        i_ic_ren,
   input  logic        i_ic_wen,
   input  logic [31:0] i_ic_wdata,
   output logic [31:0] o_ic_rdata,
   output logic        o_ic_valid,
   output logic        o_dc_ready,
   input  logic [31:0] i_dc_addr,
   input  logic        i_dc_ren,
   input  logic        i_dc_wen,
   input  logic [31:0] i_dc_wdata,
   output logic [31:0] o_dc_rdata,
   output logic        o_dc_valid,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_valid
);

   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

   arb_state_t       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] beat_q, beat_d;

   logic        ic_req, dc_req;
   logic        own_req, own_ren, own_wen;
   logic [31:0] own_addr, own_wdata;
   logic        ready_own, accept, rd_accept;
   logic        full, empty, empty_next, rsp_ok;
   logic        unused_ic_wr;

   // The instruction cache never writes; its write inputs exist only for port symmetry.
   assign unused_ic_wr = ^{i_ic_wen, i_ic_wdata};
   assign ic_req       = i_ic_ren;
   assign dc_req       = i_dc_ren | i_dc_wen;

   always_comb begin
      own_req   = ic_req;
      own_ren   = i_ic_ren;
      own_wen   = 1'b0;
      own_addr  = i_ic_addr;
      own_wdata = '0;
      if (owner_q == PORT_DC) begin
         own_req   = dc_req;
         own_ren   = i_dc_ren;
         own_wen   = i_dc_wen;
         own_addr  = i_dc_addr;
         own_wdata = i_dc_wdata;
      end
   end

   mem_rsp_tracker #(
      .MAX_OUT (MAX_OUT),
      .CNT_W   (CNT_W)
   ) u_rsp_tracker (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_inc        (rd_accept),
      .i_rsp        (i_mem_valid),
      .o_rsp_ok     (rsp_ok),
      .o_full       (full),
      .o_empty      (empty),
      .o_empty_next (empty_next)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      beat_d      = beat_q;
      ready_own   = 1'b0;
      accept      = 1'b0;
      rd_accept   = 1'b0;
      o_mem_addr  = '0;
      o_mem_ren   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_wdata = '0;

      case (state_q)
         IDLE: begin
            if (ic_req || dc_req) begin
               if (ic_req && dc_req) begin
                  owner_d = ~last_q;
               end else begin
                  owner_d = dc_req ? PORT_DC : PORT_IC;
               end
               beat_d  = '0;
               state_d = GRANT;
            end
         end

         GRANT: begin
            ready_own   = i_mem_ready && !full && (beat_q < BURST_MAX);
            accept      = own_req && ready_own;
            rd_accept   = accept && own_ren;
            o_mem_addr  = own_addr;
            o_mem_wdata = own_wdata;
            o_mem_ren   = own_ren && ready_own;
            o_mem_wen   = own_wen && ready_own;
            if (accept) begin
               beat_d = beat_q + 1'b1;
            end
            if (accept && (beat_q == BURST_MAX - 1'b1)) begin
               state_d = DRAIN;
            end else if (!own_req && empty) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end

         DRAIN: begin
            if (empty_next) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         owner_q <= PORT_IC;
         last_q  <= PORT_IC;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

   // Reads are only outstanding while their issuer holds the grant.
   assign o_ic_valid = rsp_ok && (owner_q == PORT_IC);
   assign o_dc_valid = rsp_ok && (owner_q == PORT_DC);
   assign o_ic_rdata = o_ic_valid ? i_mem_rdata : '0;
   assign o_dc_rdata = o_dc_valid ? i_mem_rdata : '0;
   assign o_ic_ready = ready_own && (owner_q == PORT_IC);
   assign o_dc_ready = ready_own && (owner_q == PORT_DC);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance plus a MAX_OUT=2 instance
// for the outstanding-read limit.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   int          n_checks;
   int          n_errors;

   logic        ic_ready, ic_ren, ic_wen, ic_valid;
   logic [31:0] ic_addr, ic_wdata, ic_rdata;
   logic        dc_ready, dc_ren, dc_wen, dc_valid;
   logic [31:0] dc_addr, dc_wdata, dc_rdata;
   logic        mem_ready, mem_ren, mem_wen, mem_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        l_ic_ready, l_ic_valid, l_dc_ready, l_dc_ren, l_dc_valid;
   logic [31:0] l_ic_rdata, l_dc_addr, l_dc_rdata;
   logic        l_mem_ready, l_mem_ren, l_mem_wen, l_mem_valid;
   logic [31:0] l_mem_addr, l_mem_wdata, l_mem_rdata;
   logic        zero1;
   logic [31:0] zero32;

   mem_arbiter u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_ic_ready  (ic_ready),
      .i_ic_addr   (ic_addr),
      .i_ic_ren    (ic_ren),
      .i_ic_wen    (ic_wen),
      .i_ic_wdata  (ic_wdata),
      .o_ic_rdata  (ic_rdata),
      .o_ic_valid  (ic_valid),
      .o_dc_ready  (dc_ready),
      .i_dc_addr   (dc_addr),
      .i_dc_ren    (dc_ren),
      .i_dc_wen    (dc_wen),
      .i_dc_wdata  (dc_wdata),
      .o_dc_rdata  (dc_rdata),
      .o_dc_valid  (dc_valid),
      .i_mem_ready (mem_ready),
      .o_mem_addr  (mem_addr),
      .o_mem_ren   (mem_ren),
      .o_mem_wen   (mem_wen),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .i_mem_valid (mem_valid)
   );

   mem_arbiter #(.MAX_OUT(2)) u_lim (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_ic_ready  (l_ic_ready),
      .i_ic_addr   (zero32),
      .i_ic_ren    (zero1),
      .i_ic_wen    (zero1),
      .i_ic_wdata  (zero32),
      .o_ic_rdata  (l_ic_rdata),
      .o_ic_valid  (l_ic_valid),
      .o_dc_ready  (l_dc_ready),
      .i_dc_addr   (l_dc_addr),
      .i_dc_ren    (l_dc_ren),
      .i_dc_wen    (zero1),
      .i_dc_wdata  (zero32),
      .o_dc_rdata  (l_dc_rdata),
      .o_dc_valid  (l_dc_valid),
      .i_mem_ready (l_mem_ready),
      .o_mem_addr  (l_mem_addr),
      .o_mem_ren   (l_mem_ren),
      .o_mem_wen   (l_mem_wen),
      .o_mem_wdata (l_mem_wdata),
      .i_mem_rdata (l_mem_rdata),
      .i_mem_valid (l_mem_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100us");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input int k);
      return 32'hD000_0000 + 32'(k);
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      zero1 = 1'b0;   zero32 = '0;
      rst_n = 1'b0;
      ic_ren = 1'b0;  ic_wen = 1'b0;  ic_addr = '0;  ic_wdata = '0;
      dc_ren = 1'b0;  dc_wen = 1'b0;  dc_addr = '0;  dc_wdata = '0;
      mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
      l_dc_ren = 1'b0; l_dc_addr = '0; l_mem_ready = 1'b0; l_mem_valid = 1'b0; l_mem_rdata = '0;

      // reset state
      step(); step();
      rst_n = 1'b1;
      #1;
      chk1("rst_ic_ready", ic_ready, 1'b0);
      chk1("rst_dc_ready", dc_ready, 1'b0);
      chk1("rst_mem_ren", mem_ren, 1'b0);
      chk1("rst_mem_wen", mem_wen, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk1("rst_dc_valid", dc_valid, 1'b0);

      // single dc read burst, responses two cycles after accept
      dc_ren = 1'b1; dc_addr = 32'h100; mem_ready = 1'b1;
      #1;
      chk1("rd_idle_ready", dc_ready, 1'b0);
      chk1("rd_idle_mem_ren", mem_ren, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         dc_addr   = 32'h100 + 32'(4 * i);
         mem_valid = (i >= 2);
         mem_rdata = (i >= 2) ? rd(i - 2) : 32'h0;
         #1;
         chk1("rd_mem_ren", mem_ren, 1'b1);
         chk32("rd_mem_addr", mem_addr, 32'h100 + 32'(4 * i));
         chk1("rd_dc_ready", dc_ready, 1'b1);
         chk1("rd_dc_valid", dc_valid, (i >= 2));
         chk32("rd_dc_rdata", dc_rdata, (i >= 2) ? rd(i - 2) : 32'h0);
         chk1("rd_ic_ready", ic_ready, 1'b0);
         chk1("rd_ic_valid", ic_valid, 1'b0);
         step();
      end
      dc_ren = 1'b0;
      for (int i = 2; i < 4; i++) begin
         mem_valid = 1'b1;
         mem_rdata = rd(i);
         #1;
         chk1("rd_drain_mem_ren", mem_ren, 1'b0);
         chk1("rd_drain_ready", dc_ready, 1'b0);
         chk1("rd_drain_valid", dc_valid, 1'b1);
         chk32("rd_drain_rdata", dc_rdata, rd(i));
         chk1("rd_drain_ic_valid", ic_valid, 1'b0);
         step();
      end
      mem_valid = 1'b0; mem_rdata = '0;
      #1;
      chk1("rd_done_valid", dc_valid, 1'b0);
      chk1("rd_done_ready", dc_ready, 1'b0);
      step();

      // tie after reset: dc first, then ic, then dc again
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ic_ren = 1'b1; ic_addr = 32'h40;
      dc_wen = 1'b1; dc_addr = 32'h300; dc_wdata = 32'h1111_0000;
      #1;
      chk1("tie_idle_ic_ready", ic_ready, 1'b0);
      chk1("tie_idle_dc_ready", dc_ready, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         dc_addr  = 32'h300 + 32'(4 * i);
         dc_wdata = 32'h1111_0000 + 32'(i);
         #1;
         chk1("tie_dc_ready", dc_ready, 1'b1);
         chk1("tie_ic_ready", ic_ready, 1'b0);
         chk1("tie_mem_wen", mem_wen, 1'b1);
         chk1("tie_mem_ren", mem_ren, 1'b0);
         chk32("tie_mem_addr", mem_addr, 32'h300 + 32'(4 * i));
         chk32("tie_mem_wdata", mem_wdata, 32'h1111_0000 + 32'(i));
         step();
      end
      dc_wen = 1'b0;
      #1;
      chk1("tie_drain_ic_ready", ic_ready, 1'b0);
      chk1("tie_drain_mem_wen", mem_wen, 1'b0);
      step();
      chk1("tie_rearb_ic_ready", ic_ready, 1'b0);
      chk1("tie_rearb_mem_ren", mem_ren, 1'b0);
      step();
      chk1("tie_ic_grant_ready", ic_ready, 1'b1);
      chk1("tie_ic_grant_ren", mem_ren, 1'b1);
      chk32("tie_ic_grant_addr", mem_addr, 32'h40);
      chk1("tie_ic_grant_dc_ready", dc_ready, 1'b0);
      step();
      ic_ren = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hCAFE_0040;
      #1;
      chk1("tie_ic_valid", ic_valid, 1'b1);
      chk32("tie_ic_rdata", ic_rdata, 32'hCAFE_0040);
      chk1("tie_ic_dc_valid", dc_valid, 1'b0);
      step();
      mem_valid = 1'b0; mem_rdata = '0;
      step();
      ic_ren = 1'b1; dc_ren = 1'b1; dc_addr = 32'h500;
      #1;
      chk1("tie2_idle_ic_ready", ic_ready, 1'b0);
      chk1("tie2_idle_dc_ready", dc_ready, 1'b0);
      step();
      chk1("tie2_dc_ready", dc_ready, 1'b1);
      chk1("tie2_ic_ready", ic_ready, 1'b0);
      chk32("tie2_mem_addr", mem_addr, 32'h500);
      step();
      ic_ren = 1'b0; dc_ren = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hCAFE_0500;
      #1;
      chk1("tie2_dc_valid", dc_valid, 1'b1);
      chk32("tie2_dc_rdata", dc_rdata, 32'hCAFE_0500);
      step();
      mem_valid = 1'b0; mem_rdata = '0;
      step(); step();

      // dc write
      dc_wen = 1'b1; dc_addr = 32'h200; dc_wdata = 32'hDEAD_BEEF;
      #1;
      chk1("wr_idle_mem_wen", mem_wen, 1'b0);
      step();
      chk1("wr_mem_wen", mem_wen, 1'b1);
      chk32("wr_mem_addr", mem_addr, 32'h200);
      chk32("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1("wr_mem_ren", mem_ren, 1'b0);
      chk1("wr_dc_ready", dc_ready, 1'b1);
      step();
      dc_wen = 1'b0;
      #1;
      chk1("wr_after_mem_wen", mem_wen, 1'b0);
      chk1("wr_after_dc_valid", dc_valid, 1'b0);
      step();
      chk1("wr_back_idle", dc_ready, 1'b0);

      // response with nothing outstanding is dropped
      mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
      #1;
      chk1("err_dc_valid", dc_valid, 1'b0);
      chk1("err_ic_valid", ic_valid, 1'b0);
      chk32("err_dc_rdata", dc_rdata, 32'h0);
      chk32("err_ic_rdata", ic_rdata, 32'h0);
      step();
      mem_valid = 1'b0; mem_rdata = '0;
      dc_ren = 1'b1; dc_addr = 32'h600;
      step();
      chk1("err_rd_ready", dc_ready, 1'b1);
      step();
      dc_ren = 1'b0;
      step();
      mem_valid = 1'b1; mem_rdata = 32'h0000_0600;
      #1;
      chk1("err_rd_valid", dc_valid, 1'b1);
      step();
      mem_valid = 1'b0; mem_rdata = '0;
      step();
      chk1("err_cnt_clean_idle", dc_ready, 1'b0);
      step();

      // reset mid-burst, then a stale response
      dc_ren = 1'b1; dc_addr = 32'h700;
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; dc_ren = 1'b0;
      #1;
      chk1("mrst_mem_ren", mem_ren, 1'b0);
      chk1("mrst_dc_ready", dc_ready, 1'b0);
      chk32("mrst_mem_addr", mem_addr, 32'h0);
      mem_valid = 1'b1; mem_rdata = 32'h0000_0700;
      #1;
      chk1("mrst_stale_valid", dc_valid, 1'b0);
      chk32("mrst_stale_rdata", dc_rdata, 32'h0);
      step();
      mem_valid = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
      step();

      // outstanding limit of 2 with 10-cycle response latency
      l_dc_ren = 1'b1; l_dc_addr = 32'h800; l_mem_ready = 1'b1;
      step();
      chk1("lim_ready_0", l_dc_ready, 1'b1);
      chk1("lim_ren_0", l_mem_ren, 1'b1);
      step();
      l_dc_addr = 32'h804;
      #1;
      chk1("lim_ready_1", l_dc_ready, 1'b1);
      step();
      l_dc_addr = 32'h808;
      #1;
      chk1("lim_full_ready", l_dc_ready, 1'b0);
      chk1("lim_full_ren", l_mem_ren, 1'b0);
      step();
      for (int k = 4; k <= 10; k++) begin
         chk1("lim_hold_ready", l_dc_ready, 1'b0);
         step();
      end
      l_mem_valid = 1'b1; l_mem_rdata = 32'hBEEF_0800;
      #1;
      chk1("lim_rsp_valid", l_dc_valid, 1'b1);
      chk32("lim_rsp_rdata", l_dc_rdata, 32'hBEEF_0800);
      chk1("lim_resume_ready", l_dc_ready, 1'b1);
      chk1("lim_resume_ren", l_mem_ren, 1'b1);
      chk32("lim_resume_addr", l_mem_addr, 32'h808);
      step();
      l_dc_addr = 32'h80C; l_mem_rdata = 32'hBEEF_0804;
      #1;
      chk1("lim_ready_3", l_dc_ready, 1'b1);
      chk1("lim_rsp2_valid", l_dc_valid, 1'b1);
      step();
      l_dc_ren = 1'b0; l_mem_valid = 1'b0; l_mem_rdata = '0;
      #1;
      chk1("lim_drain_ren", l_mem_ren, 1'b0);
      chk1("lim_drain_ready", l_dc_ready, 1'b0);
      step();
      l_mem_valid = 1'b1; l_mem_rdata = 32'hBEEF_0808;
      #1;
      chk1("lim_rsp3_valid", l_dc_valid, 1'b1);
      step();
      l_mem_rdata = 32'hBEEF_080C;
      #1;
      chk1("lim_rsp4_valid", l_dc_valid, 1'b1);
      step();
      l_mem_valid = 1'b0; l_mem_rdata = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
